// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: PC/IF-ID holds, IF-ID/ID-EX flushes,
// mult/div interlock, fetch-miss waits, and stall/flush performance counters.
module hazard_stall_ctrl #(
   parameter int MD_LATENCY = 32,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rs_ID,
   input  logic [4:0]       rt_ID,
   input  logic             use_rs_ID,
   input  logic             use_rt_ID,
   input  logic             MemRead_EX,
   input  logic [4:0]       rt_EX,
   input  logic             branch_taken_EX,
   input  logic             jump_ID,
   input  logic             md_start_ID,
   input  logic             imem_ready,
   output logic             hold_PC,
   output logic             hold_IFID,
   output logic             flush_IFID,
   output logic             flush_IDEX,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int MDC_W = $clog2(MD_LATENCY);
   localparam logic [MDC_W-1:0] MD_LOAD = MDC_W'(MD_LATENCY - 1);

   typedef enum logic [1:0] {RUN, MD_WAIT, IMISS} state_t;

   state_t           state_q, state_d;
   logic [MDC_W-1:0] md_cnt_q, md_cnt_d;
   logic             redir_pend_q, redir_pend_d;
   logic             md_busy_q, md_busy_d;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
   logic             loadUse;
   logic             runEval;

   assign loadUse = MemRead_EX && (rt_EX != 5'd0) &&
                    ((use_rs_ID && (rs_ID == rt_EX)) || (use_rt_ID && (rt_ID == rt_EX)));

   always_comb begin
      hold_PC      = 1'b0;
      hold_IFID    = 1'b0;
      flush_IFID   = 1'b0;
      flush_IDEX   = 1'b0;
      state_d      = state_q;
      md_cnt_d     = md_cnt_q;
      redir_pend_d = redir_pend_q;
      runEval      = 1'b0;

      case (state_q)
         RUN: runEval = 1'b1;
         MD_WAIT: begin
            if (md_cnt_q != '0) begin
               hold_PC    = 1'b1;
               hold_IFID  = 1'b1;
               flush_IDEX = 1'b1;
               md_cnt_d   = md_cnt_q - 1'b1;
            end else begin
               runEval = 1'b1;
            end
         end
         IMISS: begin
            if (!imem_ready) begin
               hold_PC    = 1'b1;
               flush_IFID = 1'b1;
               if (branch_taken_EX) begin
                  flush_IDEX   = 1'b1;
                  redir_pend_d = 1'b1;
               end
            end else if (redir_pend_q) begin
               // The word just fetched belongs to the squashed path: drop it, fetch the target.
               flush_IFID   = 1'b1;
               redir_pend_d = 1'b0;
               state_d      = RUN;
            end else begin
               runEval = 1'b1;
            end
         end
         default: state_d = RUN;
      endcase

      if (runEval) begin
         state_d = RUN;
         if (branch_taken_EX) begin
            flush_IFID = 1'b1;
            flush_IDEX = 1'b1;
            if (!imem_ready) begin
               redir_pend_d = 1'b1;
               state_d      = IMISS;
            end
         end else if (loadUse) begin
            hold_PC    = 1'b1;
            hold_IFID  = 1'b1;
            flush_IDEX = 1'b1;
         end else if (md_start_ID) begin
            md_cnt_d = MD_LOAD;
            state_d  = MD_WAIT;
         end else if (jump_ID) begin
            flush_IFID = 1'b1;
         end else if (!imem_ready) begin
            hold_PC    = 1'b1;
            flush_IFID = 1'b1;
            state_d    = IMISS;
         end
      end

      // Busy covers only the frozen cycles, not the final release cycle at md_cnt==0.
      md_busy_d = (state_d == MD_WAIT) && (md_cnt_d != '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= RUN;
         md_cnt_q     <= '0;
         redir_pend_q <= 1'b0;
         md_busy_q    <= 1'b0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         md_cnt_q     <= md_cnt_d;
         redir_pend_q <= redir_pend_d;
         md_busy_q    <= md_busy_d;
         stall_cnt_q  <= stall_cnt_q + CNT_W'(hold_PC);
         flush_cnt_q  <= flush_cnt_q + CNT_W'(flush_IFID & ~hold_IFID);
      end
   end

   assign md_busy   = md_busy_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios then random traffic,
// compared every cycle against a cycle-budget reference model.
module tb_hazard_stall_ctrl;

   localparam int MD_LAT = 4;
   localparam int CW     = 32;

   logic          clk;
   logic          reset;
   logic [4:0]    rs_ID, rt_ID, rt_EX;
   logic          use_rs_ID, use_rt_ID, MemRead_EX;
   logic          branch_taken_EX, jump_ID, md_start_ID, imem_ready;
   logic          hold_PC, hold_IFID, flush_IFID, flush_IDEX, md_busy;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int checks;
   int errors;

   // Reference model: remaining mult/div cycles, fetch-miss flag, wrong-path flag, counters.
   int            mdLeft;
   bit            inMiss;
   bit            wrongPath;
   logic [CW-1:0] mStall, mFlush;
   logic [3:0]    lastCtl;
   logic          lastBusy;
   int            busyCount;

   hazard_stall_ctrl #(.MD_LATENCY(MD_LAT), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .rs_ID(rs_ID), .rt_ID(rt_ID), .use_rs_ID(use_rs_ID), .use_rt_ID(use_rt_ID),
      .MemRead_EX(MemRead_EX), .rt_EX(rt_EX), .branch_taken_EX(branch_taken_EX),
      .jump_ID(jump_ID), .md_start_ID(md_start_ID), .imem_ready(imem_ready),
      .hold_PC(hold_PC), .hold_IFID(hold_IFID), .flush_IFID(flush_IFID),
      .flush_IDEX(flush_IDEX), .md_busy(md_busy),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mdLeft    = 0;
      inMiss    = 0;
      wrongPath = 0;
      mStall    = '0;
      mFlush    = '0;
   endtask

   task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                                input logic urt, input logic mr, input logic [4:0] rte,
                                input logic br, input logic jmp, input logic md, input logic rdy);
      rs_ID = rs; rt_ID = rt; use_rs_ID = urs; use_rt_ID = urt;
      MemRead_EX = mr; rt_EX = rte; branch_taken_EX = br;
      jump_ID = jmp; md_start_ID = md; imem_ready = rdy;
   endtask

   // Sample at the falling edge, compare, advance the model, then move to just after the rising edge.
   task automatic checkOutput(input string tag);
      logic [3:0] expCtl;
      bit         lu, normal, nMiss, nWrong;
      int         nMd;
      @(negedge clk);
      lu = MemRead_EX && (rt_EX != 0) &&
           ((use_rs_ID && rs_ID == rt_EX) || (use_rt_ID && rt_ID == rt_EX));
      expCtl = 4'b0000;
      normal = 1;
      nMd    = mdLeft;
      nMiss  = inMiss;
      nWrong = wrongPath;
      if (mdLeft > 1) begin
         expCtl = 4'b1101;
         nMd    = mdLeft - 1;
         normal = 0;
      end else if (inMiss && !imem_ready) begin
         expCtl = branch_taken_EX ? 4'b1011 : 4'b1010;
         if (branch_taken_EX) nWrong = 1;
         normal = 0;
      end else if (inMiss && wrongPath) begin
         expCtl = 4'b0010;
         nMiss  = 0;
         nWrong = 0;
         normal = 0;
      end
      if (normal) begin
         nMd   = 0;
         nMiss = 0;
         if (branch_taken_EX) begin
            expCtl = 4'b0011;
            if (!imem_ready) begin nMiss = 1; nWrong = 1; end
         end else if (lu) begin
            expCtl = 4'b1101;
         end else if (md_start_ID) begin
            nMd = MD_LAT;
         end else if (jump_ID) begin
            expCtl = 4'b0010;
         end else if (!imem_ready) begin
            expCtl = 4'b1010;
            nMiss  = 1;
         end
      end
      lastCtl  = {hold_PC, hold_IFID, flush_IFID, flush_IDEX};
      lastBusy = md_busy;
      checkValue({tag, ".ctl"}, lastCtl, expCtl);
      checkValue({tag, ".busy"}, md_busy, (mdLeft > 1));
      checkValue({tag, ".stall_cnt"}, stall_cnt, mStall);
      checkValue({tag, ".flush_cnt"}, flush_cnt, mFlush);
      mStall    = mStall + CW'(expCtl[3]);
      mFlush    = mFlush + CW'(expCtl[1] & ~expCtl[2]);
      mdLeft    = nMd;
      inMiss    = nMiss;
      wrongPath = nWrong;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      modelReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkValue("reset.ctl", {hold_PC, hold_IFID, flush_IFID, flush_IDEX}, 4'b0000);
      checkValue("reset.busy", md_busy, 1'b0);
      checkValue("reset.stall_cnt", stall_cnt, 0);
      checkValue("reset.flush_cnt", flush_cnt, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Load-use on rs: exactly one stall cycle.
      applyStimulus(5, 2, 1, 1, 1, 5, 0, 0, 0, 1);
      checkOutput("loaduse");
      checkValue("loaduse.first", lastCtl, 4'b1101);
      applyStimulus(5, 2, 1, 1, 0, 0, 0, 0, 0, 1);
      checkOutput("loaduse.after");
      checkValue("loaduse.count", stall_cnt, 1);

      // Load into r0 never stalls.
      applyStimulus(0, 0, 1, 1, 1, 0, 0, 0, 0, 1);
      checkOutput("r0load");
      checkValue("r0load.noStall", lastCtl, 4'b0000);

      // Mult/div issue then three frozen cycles.
      busyCount = 0;
      applyStimulus(1, 2, 1, 1, 0, 0, 0, 0, 1, 1);
      checkOutput("mdIssue");
      checkValue("mdIssue.noHold", lastCtl, 4'b0000);
      applyStimulus(1, 2, 1, 1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < MD_LAT; i++) begin
         checkOutput("mdWait");
         if (lastBusy) busyCount++;
      end
      checkValue("mdWait.busyCycles", busyCount, MD_LAT - 1);
      checkValue("mdWait.release", lastCtl, 4'b0000);

      // Taken branch overrides load-use and jump.
      applyStimulus(7, 3, 1, 0, 1, 7, 1, 1, 0, 1);
      checkOutput("branchPrio");
      checkValue("branchPrio.ctl", lastCtl, 4'b0011);

      // Fetch miss for three cycles with a branch in the middle, then wrong-path drop.
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("miss1");
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      checkOutput("miss2");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("miss3");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("missWrongPath");
      checkValue("missWrongPath.ctl", lastCtl, 4'b0010);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("missDone");

      // Asynchronous reset in the middle of a mult/div wait.
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      checkOutput("rstMdIssue");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("rstMdWait");
      #2;
      reset = 1'b0;
      #1;
      checkValue("asyncReset.busy", md_busy, 1'b0);
      checkValue("asyncReset.stall_cnt", stall_cnt, 0);
      checkValue("asyncReset.flush_cnt", flush_cnt, 0);
      modelReset();
      @(negedge clk);
      #2;
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("afterReset");
      checkValue("afterReset.run", lastCtl, 4'b0000);

      // Random traffic with small register indices so hazards are frequent.
      for (int i = 0; i < 600; i++) begin
         applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
                       ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
         checkOutput("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
